// File: rtl/pwm_duty_meter_if.sv
// PWM duty meter bus: the sampled PWM line plus the measurement results.
// master = meter side (consumes pwm_in, drives results).
// slave  = link/consumer side (drives pwm_in, reads results).
interface pwm_duty_meter_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] period_cycles;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output high_cycles,
    output period_cycles,
    output meas_valid,
    output stuck,
    output stuck_level
  );

  modport slave (
    output pwm_in,
    input  high_cycles,
    input  period_cycles,
    input  meas_valid,
    input  stuck,
    input  stuck_level
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of an asynchronous PWM line
// in CLK cycles, reports each completed period, flags a stuck line.
// Optional build macro: PWM_DEGLITCH_EN -- 3-sample majority filter after the
// synchronizer (one extra cycle of latency, rejects 1-cycle glitches).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SYNC   | no period reference yet (after reset or stuck); wait for rise
// ST_HIGH   | line high inside a measured period
// ST_LOW    | line low; next rise closes the period and reports it
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input logic             CLK,
  input logic             RST,
  pwm_duty_meter_if.master bus
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             s, s_d_q;
  logic             rise, fall, timeout;
  logic [CNT_W-1:0] per_ctr_q, hi_ctr_q;
  logic [CNT_W-1:0] high_q, period_q;
  logic             valid_q;
  logic             stuck_q, stuck_d;
  logic             stuck_lvl_q, stuck_lvl_d;
  logic             report;

  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEGLITCH_EN
  logic hist1_q, hist2_q;

  // sample history for the majority vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  assign s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign s = sync2_q;
`endif

  // delayed copy of the conditioned level for edge detection
  always_ff @(posedge CLK) begin
    if (RST) s_d_q <= 1'b0;
    else     s_d_q <= s;
  end

  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  // a rise in the same cycle wins over the timeout
  assign timeout = (per_ctr_q == TIMEOUT_C) & ~rise;

  // period and high-time counters, restarted at 1 on every rise, saturating
  always_ff @(posedge CLK) begin
    if (RST) begin
      per_ctr_q <= '0;
      hi_ctr_q  <= '0;
    end else if (rise) begin
      per_ctr_q <= CNT_ONE;
      hi_ctr_q  <= CNT_ONE;
    end else begin
      if (per_ctr_q != CNT_MAX) per_ctr_q <= per_ctr_q + CNT_ONE;
      if (s && (hi_ctr_q != CNT_MAX)) hi_ctr_q <= hi_ctr_q + CNT_ONE;
    end
  end

  // state, stuck flag and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_SYNC;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      valid_q     <= 1'b0;
      high_q      <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      valid_q     <= report;
      if (report) begin
        high_q   <= hi_ctr_q;
        period_q <= per_ctr_q;
      end
    end
  end

  // next-state, stuck tracking and report strobe
  always_comb begin
    state_d     = state_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_q ? s : stuck_lvl_q;
    report      = 1'b0;
    if (timeout) begin
      state_d     = ST_SYNC;
      stuck_d     = 1'b1;
      stuck_lvl_d = s;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (rise) begin
            state_d = ST_HIGH;
            stuck_d = 1'b0;
          end
        end
        ST_HIGH: begin
          if (fall) state_d = ST_LOW;
        end
        ST_LOW: begin
          if (rise) begin
            state_d = ST_HIGH;
            report  = 1'b1;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  assign bus.high_cycles   = high_q;
  assign bus.period_cycles = period_q;
  assign bus.meas_valid    = valid_q;
  assign bus.stuck         = stuck_q;
  assign bus.stuck_level   = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus pushes the expected
// {high, period} of each period that a rise closes; a monitor pops on meas_valid.
module tb_pwm_duty_meter;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
`ifdef PWM_DEGLITCH_EN
  localparam int  LAT      = 1;
  localparam bit  FILTERED = 1'b1;
`else
  localparam int  LAT      = 0;
  localparam bit  FILTERED = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pwm_duty_meter_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  logic        prev_v;
  int          prev_h, prev_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: every report must match the oldest expected period
  always @(negedge CLK) begin
    if (!RST && bus.meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report actual=%0d/%0d required=none",
                 bus.high_cycles, bus.period_cycles);
      end else begin
        exp_e = exp_q.pop_front();
        check("report_high", 32'(bus.high_cycles), {16'd0, exp_e[31:16]});
        check("report_period", 32'(bus.period_cycles), {16'd0, exp_e[15:0]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // rising edge at the start of a new period closes the previous one
  task automatic start_rise(input bit push_en);
    bus.pwm_in = 1'b1;
    if (push_en && prev_v) exp_q.push_back({16'(prev_h), 16'(prev_p)});
  endtask

  task automatic period(input int h, input int p, input bit push_en);
    start_rise(push_en);
    prev_v = push_en;
    prev_h = h;
    prev_p = p;
    tick(h);
    bus.pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high"},   32'(bus.high_cycles),   32'd0);
    check({tag, "_period"}, 32'(bus.period_cycles), 32'd0);
    check({tag, "_valid"},  32'(bus.meas_valid),    32'd0);
    check({tag, "_stuck"},  32'(bus.stuck),         32'd0);
    check({tag, "_level"},  32'(bus.stuck_level),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.pwm_in = 1'b0;
    prev_v = 1'b0;
    prev_h = 0;
    prev_p = 0;
    RST = 1'b1;
    tick(3);
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    tick(4);

    // duty 5/16
    repeat (4) period(5, 16, 1'b1);

    // held high: the closing rise reports 5/16, then stuck exactly at the bound
    start_rise(1'b1);
    prev_v = 1'b0;
    repeat (102 + LAT) @(posedge CLK);
    @(negedge CLK);
    check("stuck_hi_before_bound", 32'(bus.stuck), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("stuck_hi_at_bound", 32'(bus.stuck), 32'd1);
    check("stuck_hi_level", 32'(bus.stuck_level), 32'd1);
    check("stuck_hi_keep_high", 32'(bus.high_cycles), 32'd5);
    check("stuck_hi_keep_period", 32'(bus.period_cycles), 32'd16);
    @(posedge CLK); #1;
    bus.pwm_in = 1'b0;
    tick(5);
    check("stuck_after_fall", 32'(bus.stuck), 32'd1);

    // resume 8/16: first rise clears stuck without a report
    period(8, 16, 1'b1);
    check("stuck_cleared", 32'(bus.stuck), 32'd0);
    repeat (2) period(8, 16, 1'b1);

    // held low
    prev_v = 1'b0;
    tick(120);
    check("stuck_lo", 32'(bus.stuck), 32'd1);
    check("stuck_lo_level", 32'(bus.stuck_level), 32'd0);
    check("stuck_lo_keep_high", 32'(bus.high_cycles), 32'd8);
    check("stuck_lo_keep_period", 32'(bus.period_cycles), 32'd16);

    // duty 15/16: single-cycle low
    repeat (8) period(15, 16, !FILTERED);
    if (FILTERED) begin
      check("d15_stuck", 32'(bus.stuck), 32'd1);
      check("d15_level", 32'(bus.stuck_level), 32'd1);
    end else begin
      check("d15_stuck", 32'(bus.stuck), 32'd0);
      check("d15_high", 32'(bus.high_cycles), 32'd15);
      check("d15_period", 32'(bus.period_cycles), 32'd16);
    end

    // reset in the middle of a period
    start_rise(!FILTERED);
    prev_v = 1'b0;
    tick(6);
    RST = 1'b1;
    bus.pwm_in = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_all_zero("midrst");
    @(posedge CLK); #1;
    tick(2);
    RST = 1'b0;
    tick(3);

    // duty 3/16 then 12/16, closed by a final rise
    repeat (3) period(3, 16, 1'b1);
    repeat (3) period(12, 16, 1'b1);
    start_rise(1'b1);
    prev_v = 1'b0;
    tick(6);
    bus.pwm_in = 1'b0;
    tick(10);
    check("final_high", 32'(bus.high_cycles), 32'd12);
    check("final_period", 32'(bus.period_cycles), 32'd16);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
